muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU with architectural HI/LO registers. It sits beside the single-cycle ALU in the execute stage.
- Accepts one operation, iterates a radix-2 shift-add (multiply) or restoring (divide) datapath, then applies sign correction and writes HI/LO.
- Holds `busy` so the pipeline stalls on MFHI/MFLO and on new mul/div issue.
- Also services MTHI/MTLO writes.

Parameters:
- `WIDTH`, 32: operand width and HI/LO width.
- `FAST_DIV0`, 1: when 1, divide-by-zero completes in 2 cycles; when 0, it runs the full iteration.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous active-high reset.
- `op_valid` in 1: issue request, sampled only when `busy`=0.
- `op_code` in 2: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `op_x` in WIDTH: rs operand (multiplicand / dividend).
- `op_y` in WIDTH: rt operand (multiplier / divisor).
- `hi_we` in 1: MTHI write strobe.
- `lo_we` in 1: MTLO write strobe.
- `wr_data` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse, HI/LO valid with the new result.
- `div_by_zero` out 1: sticky until next accepted op; set when DIV/DIVU has `op_y`=0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

Behaviour:
- Reset (`rst`=1 at edge):
  - `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0; state=IDLE; iteration counter=0.
  - Reset mid-operation aborts with no `done` pulse.
- States: IDLE, RUN, FIX.
- IDLE:
  - On edge with `op_valid`=1: latch operands.
    - Signed ops: store absolute values and record result signs (product sign = x^y; quotient sign = x^y; remainder sign = x).
    - Clear counter; clear `div_by_zero`; go to RUN.
  - Else if `hi_we` / `lo_we`: write `wr_data` to HI / LO. Both may be written in the same cycle.
  - `op_valid` with `hi_we`/`lo_we` in the same cycle: the op is accepted and the writes are dropped.
- RUN:
  - One iteration per cycle for exactly WIDTH cycles; counter counts 0..WIDTH-1, then go to FIX.
  - Multiply: 2*WIDTH-bit accumulator, add shifted multiplicand when multiplier LSB=1, shift right.
  - Divide: shift remainder left with next dividend bit, subtract divisor, restore if negative, shift quotient bit in.
  - DIV/DIVU with `op_y`=0 and `FAST_DIV0`=1: skip RUN, go directly IDLE -> FIX.
- FIX (1 cycle):
  - Apply negation per recorded signs.
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - Go to IDLE. `done`=1 during the cycle after the FIX edge.
- Latency:
  - Accept edge E0; HI/LO updated at edge E(WIDTH+1) = E33.
  - `busy`=1 from after E0 through E33; `busy` falls and `done` rises in the same cycle.
  - Divide-by-zero with `FAST_DIV0`: HI/LO updated at E1, `done` in the following cycle.
- Arithmetic rules:
  - MULT: full signed 64-bit product. MULTU: unsigned.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap and no flag.
  - Divide by zero (either signedness): HI=`op_x`, LO=all ones, `div_by_zero`=1.
- While `busy`=1: `op_valid`, `hi_we` and `lo_we` are ignored. HI/LO hold their previous values until the FIX edge. The pipeline is required to stall, so ignored requests are not an error.
- Back-to-back: a new op may be accepted in the same cycle `done`=1, since `busy`=0 there.
- `hi`/`lo` are direct register outputs; there is no combinational path from inputs to any output.

Test Plan:
- MULT x=7, y=0xFFFFFFFD after reset -> `busy` high 33 cycles, then `done` pulse; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU x=y=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then MULT on the same operands issued in the `done` cycle -> HI=0, LO=1.
- DIV x=0xFFFFFFF9 (-7), y=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU x=7, y=2 -> LO=3, HI=1.
- DIV x=0x80000000, y=0xFFFFFFFF -> LO=0x80000000, HI=0, `div_by_zero`=0; DIVU x=5, y=0 -> `done` 2 cycles after accept, HI=5, LO=0xFFFFFFFF, `div_by_zero`=1.
- MTHI 0x1234 and MTLO 0x5678 in IDLE -> HI=0x1234, LO=0x5678 next cycle. During a MULT, `hi_we` with 0xAAAA -> ignored, HI becomes the product result.
- Start DIVU 100/3, assert `rst` at cycle 10 -> next cycle `busy`=0, HI=LO=0, no `done` pulse. A subsequent op runs normally (LO=33, HI=1).

Source files
------------

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO registers.
// Revision : 1.0
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH     = 32,
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_a;       // product high half / partial remainder
    logic [WIDTH-1:0]  r_b;       // product low half + multiplier / dividend -> quotient
    logic [WIDTH-1:0]  r_m;       // multiplicand / divisor magnitude
    logic              r_is_div;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_done;
    logic              r_dbz;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;

    logic              w_is_div;
    logic              w_signed;
    logic              w_x_neg;
    logic              w_y_neg;
    logic              w_y_zero;
    logic              w_fast0;
    logic [WIDTH-1:0]  w_x_abs;
    logic [WIDTH-1:0]  w_y_abs;
    logic [WIDTH:0]    w_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]    w_trial;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]  w_q_fix;
    logic [WIDTH-1:0]  w_r_fix;
    logic [WIDTH-1:0]  w_hi_res;
    logic [WIDTH-1:0]  w_lo_res;

    assign w_is_div = op_code[1];
    assign w_signed = ~op_code[0];
    assign w_x_neg  = w_signed & op_x[WIDTH-1];
    assign w_y_neg  = w_signed & op_y[WIDTH-1];
    assign w_x_abs  = w_x_neg ? -op_x : op_x;
    assign w_y_abs  = w_y_neg ? -op_y : op_y;
    assign w_y_zero = (op_y == '0);
    assign w_fast0  = w_is_div & w_y_zero & FAST_DIV0;

    // Shift-add step: carry out of the add lands in the top bit after the shift.
    assign w_sum     = {1'b0, r_a} + {1'b0, r_m};
    assign w_mul_nxt = r_b[0] ? {w_sum, r_b[WIDTH-1:1]}
                              : {1'b0, r_a, r_b[WIDTH-1:1]};

    // Restoring step: bit WIDTH of the trial difference is set exactly when it went negative.
    assign w_trial = {r_a, r_b[WIDTH-1]} - {1'b0, r_m};

    assign w_prod_fix = r_neg_q ? -{r_a, r_b} : {r_a, r_b};
    assign w_q_fix    = r_neg_q ? -r_b : r_b;
    assign w_r_fix    = r_neg_r ? -r_a : r_a;
    assign w_hi_res   = r_is_div ? w_r_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_lo_res   = r_is_div ? w_q_fix : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (op_valid) w_state_nxt = w_fast0 ? S_FIX : S_RUN;
            S_RUN:   if (r_cnt == c_LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_cnt    <= '0;
                        r_dbz    <= w_is_div & w_y_zero;
                        r_is_div <= w_is_div;
                        r_m      <= w_is_div ? w_y_abs : w_x_abs;
                        if (!w_is_div) begin
                            r_a     <= '0;
                            r_b     <= w_y_abs;
                            r_neg_q <= w_x_neg ^ w_y_neg;
                            r_neg_r <= 1'b0;
                        end else if (w_fast0) begin
                            // Preload the divide-by-zero answer so FIX produces HI=x, LO=all ones.
                            r_a     <= w_x_abs;
                            r_b     <= '1;
                            r_neg_q <= 1'b0;
                            r_neg_r <= w_x_neg;
                        end else begin
                            r_a     <= '0;
                            r_b     <= w_x_abs;
                            r_neg_q <= (w_x_neg ^ w_y_neg) & ~w_y_zero;
                            r_neg_r <= w_x_neg;
                        end
                    end else begin
                        if (hi_we) r_hi <= wr_data;
                        if (lo_we) r_lo <= wr_data;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + c_ONE;
                    if (r_is_div) begin
                        if (!w_trial[WIDTH]) begin
                            r_a <= w_trial[WIDTH-1:0];
                            r_b <= {r_b[WIDTH-2:0], 1'b1};
                        end else begin
                            r_a <= {r_a[WIDTH-2:0], r_b[WIDTH-1]};
                            r_b <= {r_b[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {r_a, r_b} <= w_mul_nxt;
                    end
                end
                S_FIX: begin
                    r_hi <= w_hi_res;
                    r_lo <= w_lo_res;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Self-checking bench for muldiv_seq against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] op_x;
    logic [31:0] op_y;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_seq #(.WIDTH(32), .FAST_DIV0(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_x        (op_x),
        .op_y        (op_y),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Reference: plain MIPS arithmetic on 64-bit integers.
    function automatic void model(input logic [1:0] code, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output logic edbz);
        logic [63:0] p;
        longint      sx;
        longint      sy;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        edbz = 1'b0;
        eh   = '0;
        el   = '0;
        case (code)
            2'd0: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
            2'd1: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFF_FFFF; edbz = 1'b1;
                end else if (code == 2'd2) begin
                    el = 32'(sx / sy);
                    eh = 32'(sx % sy);
                end else begin
                    el = x / y;
                    eh = x % y;
                end
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] code, input logic [31:0] y);
        return (code[1] && y == 32'd0) ? 1 : 33;
    endfunction

    // Called at a falling edge; the op is accepted at the next rising edge.
    task automatic issue(input logic [1:0] code, input logic [31:0] x, input logic [31:0] y,
                         input logic wh, input logic wl, input logic [31:0] wd);
        op_valid = 1'b1; op_code = code; op_x = x; op_y = y;
        hi_we = wh; lo_we = wl; wr_data = wd;
        @(negedge clk);
        op_valid = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // Returns the number of falling edges from the accept until done, or -1 on timeout.
    task automatic wait_done(input logic poke, output int lat, output int busy_cyc, output bit held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi; l0 = lo;
        lat = -1; busy_cyc = 0; held = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin lat = k; break; end
            if (busy) busy_cyc++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            if (poke) begin hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h0000_AAAA; end
        end
        hi_we = 1'b0; lo_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b want 0", div_by_zero); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
    endtask

    task automatic test_mult();
        int lat; int bc; bit held;
        logic [31:0] eh; logic [31:0] el; logic ed;
        model(2'd0, 32'd7, 32'hFFFF_FFFD, eh, el, ed);
        issue(2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0);
        wait_done(1'b0, lat, bc, held);
        n_checks++; if (lat !== 33) $display("FAIL mult_latency: got %0d want 33", lat); else n_pass++;
        n_checks++; if (bc !== 33) $display("FAIL mult_busy_cycles: got %0d want 33", bc); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mult_busy_at_done: got %b want 0", busy); else n_pass++;
        n_checks++; if (!held) $display("FAIL mult_hilo_hold: got changed want held"); else n_pass++;
        n_checks++; if (hi !== eh) $display("FAIL mult_hi: got %h want %h", hi, eh); else n_pass++;
        n_checks++; if (lo !== el) $display("FAIL mult_lo: got %h want %h", lo, el); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL done_single_pulse: got %b want 0", done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; int bc; bit held;
        logic [31:0] eh; logic [31:0] el; logic ed;
        @(negedge clk);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        wait_done(1'b0, lat, bc, held);
        model(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, eh, el, ed);
        n_checks++; if (hi !== eh) $display("FAIL multu_hi: got %h want %h", hi, eh); else n_pass++;
        n_checks++; if (lo !== el) $display("FAIL multu_lo: got %h want %h", lo, el); else n_pass++;
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: got busy %b want 1", busy); else n_pass++;
        wait_done(1'b0, lat, bc, held);
        model(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, eh, el, ed);
        n_checks++; if (lat !== 33) $display("FAIL b2b_latency: got %0d want 33", lat); else n_pass++;
        n_checks++; if (hi !== eh) $display("FAIL b2b_mult_hi: got %h want %h", hi, eh); else n_pass++;
        n_checks++; if (lo !== el) $display("FAIL b2b_mult_lo: got %h want %h", lo, el); else n_pass++;
    endtask

    task automatic test_div();
        logic [1:0]  codes [4] = '{2'd2, 2'd3, 2'd2, 2'd3};
        logic [31:0] xs    [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5};
        logic [31:0] ys    [4] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
        int lat; int bc; bit held;
        logic [31:0] eh; logic [31:0] el; logic ed;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            model(codes[i], xs[i], ys[i], eh, el, ed);
            issue(codes[i], xs[i], ys[i], 1'b0, 1'b0, 32'd0);
            wait_done(1'b0, lat, bc, held);
            n_checks++; if (lat !== model_lat(codes[i], ys[i]))
                $display("FAIL div%0d_latency: got %0d want %0d", i, lat, model_lat(codes[i], ys[i])); else n_pass++;
            n_checks++; if (hi !== eh) $display("FAIL div%0d_hi: got %h want %h", i, hi, eh); else n_pass++;
            n_checks++; if (lo !== el) $display("FAIL div%0d_lo: got %h want %h", i, lo, el); else n_pass++;
            n_checks++; if (div_by_zero !== ed) $display("FAIL div%0d_dbz: got %b want %b", i, div_by_zero, ed); else n_pass++;
        end
        // Sticky flag clears on the next accepted op.
        @(negedge clk);
        issue(2'd3, 32'd9, 32'd3, 1'b0, 1'b0, 32'd0);
        n_checks++; if (div_by_zero !== 1'b0) $display("FAIL dbz_clear_on_accept: got %b want 0", div_by_zero); else n_pass++;
        wait_done(1'b0, lat, bc, held);
    endtask

    task automatic test_mthi_mtlo();
        int lat; int bc; bit held;
        logic [31:0] eh; logic [31:0] el; logic ed;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        n_checks++; if (hi !== 32'h1234) $display("FAIL mthi: got %h want 00001234", hi); else n_pass++;
        hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        n_checks++; if (lo !== 32'h5678) $display("FAIL mtlo: got %h want 00005678", lo); else n_pass++;
        n_checks++; if (hi !== 32'h1234) $display("FAIL mtlo_hi_kept: got %h want 00001234", hi); else n_pass++;
        // Writes during a multiply are dropped.
        model(2'd1, 32'd1000, 32'd3000, eh, el, ed);
        issue(2'd1, 32'd1000, 32'd3000, 1'b0, 1'b0, 32'd0);
        wait_done(1'b1, lat, bc, held);
        n_checks++; if (!held) $display("FAIL busy_write_ignored: got changed want held"); else n_pass++;
        n_checks++; if (hi !== eh) $display("FAIL poke_hi: got %h want %h", hi, eh); else n_pass++;
        n_checks++; if (lo !== el) $display("FAIL poke_lo: got %h want %h", lo, el); else n_pass++;
        // Op wins over simultaneous writes.
        @(negedge clk);
        model(2'd1, 32'd3, 32'd4, eh, el, ed);
        issue(2'd1, 32'd3, 32'd4, 1'b1, 1'b1, 32'hDEAD_BEEF);
        wait_done(1'b0, lat, bc, held);
        n_checks++; if (hi !== eh) $display("FAIL op_over_wr_hi: got %h want %h", hi, eh); else n_pass++;
        n_checks++; if (lo !== el) $display("FAIL op_over_wr_lo: got %h want %h", lo, el); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int lat; int bc; bit held;
        bit saw_done;
        @(negedge clk);
        issue(2'd3, 32'd100, 32'd3, 1'b0, 1'b0, 32'd0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL midrst_hi: got %h want 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL midrst_lo: got %h want 0", lo); else n_pass++;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (saw_done) $display("FAIL midrst_no_done: got pulse want none"); else n_pass++;
        issue(2'd3, 32'd100, 32'd3, 1'b0, 1'b0, 32'd0);
        wait_done(1'b0, lat, bc, held);
        n_checks++; if (lo !== 32'd33) $display("FAIL after_rst_lo: got %h want 00000021", lo); else n_pass++;
        n_checks++; if (hi !== 32'd1) $display("FAIL after_rst_hi: got %h want 00000001", hi); else n_pass++;
    endtask

    task automatic test_random();
        int lat; int bc; bit held;
        logic [31:0] eh; logic [31:0] el; logic ed;
        logic [1:0]  c;
        logic [31:0] x;
        logic [31:0] y;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            c = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if (i % 7 == 3) y = 32'd0;
            if (i % 5 == 1) y = 32'($urandom_range(1, 9));
            if (i % 11 == 4) x = 32'h8000_0000;
            if (i % 13 == 6) y = 32'hFFFF_FFFF;
            model(c, x, y, eh, el, ed);
            issue(c, x, y, 1'b0, 1'b0, 32'd0);
            wait_done(1'b0, lat, bc, held);
            n_checks++; if (lat !== model_lat(c, y))
                $display("FAIL rnd%0d_latency: op %0d got %0d want %0d", i, c, lat, model_lat(c, y)); else n_pass++;
            n_checks++; if (hi !== eh)
                $display("FAIL rnd%0d_hi: op %0d x %h y %h got %h want %h", i, c, x, y, hi, eh); else n_pass++;
            n_checks++; if (lo !== el)
                $display("FAIL rnd%0d_lo: op %0d x %h y %h got %h want %h", i, c, x, y, lo, el); else n_pass++;
            n_checks++; if (div_by_zero !== ed)
                $display("FAIL rnd%0d_dbz: got %b want %b", i, div_by_zero, ed); else n_pass++;
            // Half the time the next op issues in the done cycle itself.
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = 2'd0; op_x = '0; op_y = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_mthi_mtlo();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
